// File: rtl/riscv_pkg.sv
// Shared RV32I constants: data path widths and funct3 encodings for branches and ALU ops.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [2:0] ADD_SUB = 3'b000;
    localparam logic [2:0] SLL     = 3'b001;
    localparam logic [2:0] SLT     = 3'b010;
    localparam logic [2:0] SLTU    = 3'b011;
    localparam logic [2:0] XOR     = 3'b100;
    localparam logic [2:0] SRL_SRA = 3'b101;
    localparam logic [2:0] OR      = 3'b110;
    localparam logic [2:0] AND     = 3'b111;

endpackage

// File: rtl/execute_alu.sv
// Combinational RV32I ALU plus the comparator flags shared with branch resolution.
module execute_alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [2:0]      func3,
    input  logic            func7,
    input  logic            is_reg,
    output logic [XLEN-1:0] alu_result,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    logic [4:0] shamt;

    assign shamt = operand_b[4:0];
    assign eq    = (operand_a == operand_b);
    assign lt    = ($signed(operand_a) < $signed(operand_b));
    assign ltu   = (operand_a < operand_b);

    always_comb begin
        alu_result = '0;
        case (func3)
            // Immediate forms reuse bit 30 as immediate data, so only OP may subtract.
            ADD_SUB: alu_result = (func7 && is_reg) ? operand_a - operand_b
                                                    : operand_a + operand_b;
            SLL:     alu_result = operand_a << shamt;
            SLT:     alu_result = {{(XLEN-1){1'b0}}, lt};
            SLTU:    alu_result = {{(XLEN-1){1'b0}}, ltu};
            XOR:     alu_result = operand_a ^ operand_b;
            SRL_SRA: alu_result = func7 ? XLEN'($signed(operand_a) >>> shamt)
                                        : operand_a >> shamt;
            OR:      alu_result = operand_a | operand_b;
            AND:     alu_result = operand_a & operand_b;
            default: alu_result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// RV32I execute stage: class muxing, PC arithmetic and the single output register stage.
module execute
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_store,
    input  logic                 is_load,
    input  logic                 is_branch,
    input  logic                 is_jump,
    input  logic                 is_reg,
    input  logic                 is_alu,
    input  logic [XLEN-1:0]      operand_a,
    input  logic [XLEN-1:0]      operand_b,
    input  logic [XLEN-1:0]      branch_dest,
    input  logic [REG_IDX_W-1:0] dest_i,
    output logic [REG_IDX_W-1:0] dest_o,
    input  logic [2:0]           func3,
    input  logic                 func7,
    output logic [XLEN-1:0]      result,
    input  logic [XLEN-1:0]      curr_pc,
    output logic [XLEN-1:0]      next_pc
);

    logic [XLEN-1:0]      alu_result;
    logic                 eq, lt, ltu;
    logic                 taken;
    logic [XLEN-1:0]      pc4, ab_sum;
    logic [XLEN-1:0]      result_d, result_q, next_pc_d, next_pc_q;
    logic [REG_IDX_W-1:0] dest_d, dest_q;

    execute_alu u_alu (
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .func3      (func3),
        .func7      (func7),
        .is_reg     (is_reg),
        .alu_result (alu_result),
        .eq         (eq),
        .lt         (lt),
        .ltu        (ltu)
    );

    assign pc4    = curr_pc + 32'd4;
    assign ab_sum = operand_a + operand_b;

    always_comb begin
        taken = 1'b0;
        case (func3)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt;
            BGE:     taken = !lt;
            BLTU:    taken = ltu;
            BGEU:    taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        result_d  = '0;
        dest_d    = '0;
        next_pc_d = pc4;
        if (is_branch) begin
            if (taken) next_pc_d = curr_pc + branch_dest;
        end else if (is_jump) begin
            result_d  = pc4;
            dest_d    = dest_i;
            next_pc_d = is_reg ? {ab_sum[XLEN-1:1], 1'b0} : curr_pc + operand_a;
        end else if (is_load || is_store) begin
            result_d = ab_sum;
            dest_d   = is_load ? dest_i : '0;
        end else if (is_alu) begin
            result_d = alu_result;
            dest_d   = dest_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q  <= '0;
            dest_q    <= '0;
            next_pc_q <= '0;
        end else begin
            result_q  <= result_d;
            dest_q    <= dest_d;
            next_pc_q <= next_pc_d;
        end
    end

    assign result  = result_q;
    assign dest_o  = dest_q;
    assign next_pc = next_pc_q;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: expectations queued at drive time, popped after each edge.
module tb_execute;

    localparam logic [5:0] F_BR = 6'b100000;
    localparam logic [5:0] F_JP = 6'b010000;
    localparam logic [5:0] F_LD = 6'b001000;
    localparam logic [5:0] F_ST = 6'b000100;
    localparam logic [5:0] F_RG = 6'b000010;
    localparam logic [5:0] F_AL = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu;
    logic [31:0] operand_a, operand_b, branch_dest, curr_pc;
    logic [4:0]  dest_i;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  dest_o;
    logic [31:0] result, next_pc;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  dst;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    execute dut (
        .clk         (clk),
        .reset       (reset),
        .is_store    (is_store),
        .is_load     (is_load),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_reg      (is_reg),
        .is_alu      (is_alu),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .branch_dest (branch_dest),
        .dest_i      (dest_i),
        .dest_o      (dest_o),
        .func3       (func3),
        .func7       (func7),
        .result      (result),
        .curr_pc     (curr_pc),
        .next_pc     (next_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] fl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] bd, input logic [4:0] di, input logic [2:0] f3,
                          input logic f7, input logic [31:0] pc);
        {is_branch, is_jump, is_load, is_store, is_reg, is_alu} = fl;
        operand_a = a; operand_b = b; branch_dest = bd; dest_i = di;
        func3 = f3; func7 = f7; curr_pc = pc;
    endtask

    task automatic drive(input string tag, input logic [5:0] fl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] bd, input logic [4:0] di,
                         input logic [2:0] f3, input logic f7, input logic [31:0] pc,
                         input logic [31:0] eres, input logic [4:0] edst, input logic [31:0] enpc);
        exp_t e;
        @(negedge clk);
        set_in(fl, a, b, bd, di, f3, f7, pc);
        e.tag = tag; e.res = eres; e.dst = edst; e.npc = enpc;
        exp_q.push_back(e);
    endtask

    // Independent reference for the ALU op set.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic f7, input logic rg);
        int sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: return (f7 && rg) ? a + (~b + 32'd1) : a + b;
            3'd1: return a << sh;
            3'd2: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'(signed'(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.tag, ".result"}, result, e.res);
                chk({e.tag, ".dest"}, {27'd0, dest_o}, {27'd0, e.dst});
                chk({e.tag, ".next_pc"}, next_pc, e.npc);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a, b, pc;
        logic [2:0]  f3;
        logic        f7, rg;

        // Load a nonzero state, then verify reset clears it without a clock edge.
        set_in(F_JP, 32'd100, 32'd0, 32'd0, 5'd7, 3'd0, 1'b0, 32'd64);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_async.result", result, 32'd0);
        chk("rst_async.dest", {27'd0, dest_o}, 32'd0);
        chk("rst_async.next_pc", next_pc, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        drive("beq",   F_BR, 32'd200, 32'd200, 32'd20, 5'd10, 3'b000, 1'b0, 32'd20, 32'd0, 5'd0, 32'd40);
        drive("bne",   F_BR, 32'd200, 32'd200, 32'd20, 5'd10, 3'b001, 1'b0, 32'd20, 32'd0, 5'd0, 32'd24);
        drive("blt",   F_BR, 32'd100, -32'sd300, 32'd80, 5'd1, 3'b100, 1'b0, 32'd40, 32'd0, 5'd0, 32'd44);
        drive("bge",   F_BR, 32'd100, 32'd100, 32'd16, 5'd1, 3'b101, 1'b0, 32'd12, 32'd0, 5'd0, 32'd28);
        drive("bltu",  F_BR, 32'd2200000000, 32'd10, 32'd400, 5'd1, 3'b110, 1'b0, 32'd20, 32'd0, 5'd0, 32'd24);
        drive("bgeu",  F_BR, 32'd2200000000, 32'd10, 32'd400, 5'd1, 3'b111, 1'b0, 32'd20, 32'd0, 5'd0, 32'd420);
        drive("b010",  F_BR, 32'd5, 32'd5, 32'd400, 5'd1, 3'b010, 1'b0, 32'd20, 32'd0, 5'd0, 32'd24);
        drive("br_pri", F_BR | F_JP | F_AL, 32'd1, 32'd2, 32'd8, 5'd3, 3'b001, 1'b0, 32'd100, 32'd0, 5'd0, 32'd108);
        drive("jal",   F_JP, 32'd20000, 32'd0, 32'd0, 5'd31, 3'd0, 1'b0, 32'd20, 32'd24, 5'd31, 32'd20020);
        drive("jalr",  F_JP | F_RG, 32'd32, 32'd16, 32'd0, 5'd11, 3'd0, 1'b0, 32'd4, 32'd8, 5'd11, 32'd48);
        drive("jalr_odd", F_JP | F_RG, 32'd33, 32'd0, 32'd0, 5'd11, 3'd0, 1'b0, 32'd4, 32'd8, 5'd11, 32'd32);
        drive("jp_pri", F_JP | F_LD, 32'd8, 32'd4, 32'd0, 5'd2, 3'd0, 1'b0, 32'd0, 32'd4, 5'd2, 32'd8);
        drive("add",   F_AL, 32'd100, -32'sd200, 32'd0, 5'd9, 3'd0, 1'b0, 32'd8, 32'hFFFFFF9C, 5'd9, 32'd12);
        drive("addi_f7", F_AL, 32'd5, 32'd7, 32'd0, 5'd9, 3'd0, 1'b1, 32'd8, 32'd12, 5'd9, 32'd12);
        drive("sub",   F_AL | F_RG, 32'd5, 32'd7, 32'd0, 5'd9, 3'd0, 1'b1, 32'd8, 32'hFFFFFFFE, 5'd9, 32'd12);
        drive("sra",   F_AL | F_RG, 32'h80000000, 32'd4, 32'd0, 5'd4, 3'd5, 1'b1, 32'd0, 32'hF8000000, 5'd4, 32'd4);
        drive("srl",   F_AL | F_RG, 32'h80000000, 32'd4, 32'd0, 5'd4, 3'd5, 1'b0, 32'd0, 32'h08000000, 5'd4, 32'd4);
        drive("sltu",  F_AL | F_RG, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd6, 3'd3, 1'b0, 32'd0, 32'd0, 5'd6, 32'd4);
        drive("slt",   F_AL | F_RG, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd6, 3'd2, 1'b0, 32'd0, 32'd1, 5'd6, 32'd4);
        drive("sll",   F_AL, 32'h0000000F, 32'h00000024, 32'd0, 5'd6, 3'd1, 1'b0, 32'd0, 32'h000000F0, 5'd6, 32'd4);
        drive("load",  F_LD, 32'h1000, -32'sd4, 32'd0, 5'd5, 3'd2, 1'b0, 32'd200, 32'hFFC, 5'd5, 32'd204);
        drive("store", F_ST, 32'h1000, -32'sd4, 32'd0, 5'd5, 3'd2, 1'b0, 32'd200, 32'hFFC, 5'd0, 32'd204);
        drive("mem_pri", F_LD | F_AL, 32'd3, 32'd4, 32'd0, 5'd8, 3'd4, 1'b0, 32'd0, 32'd7, 5'd8, 32'd4);
        drive("bubble", 6'b000000, 32'd3, 32'd4, 32'd0, 5'd8, 3'd0, 1'b0, 32'hFFFFFFFC, 32'd0, 5'd0, 32'd0);
        drive("x0_dest", F_AL, 32'd1, 32'd2, 32'd0, 5'd0, 3'd6, 1'b0, 32'd0, 32'd3, 5'd0, 32'd4);

        for (int i = 0; i < 12; i++) begin
            a  = $urandom; b = $urandom; pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            f3 = 3'($urandom_range(0, 7)); f7 = 1'($urandom_range(0, 1)); rg = 1'($urandom_range(0, 1));
            drive($sformatf("alu_rnd%0d", i), F_AL | (rg ? F_RG : 6'd0), a, b, 32'd0, 5'd12, f3, f7, pc,
                  alu_ref(a, b, f3, f7, rg), 5'd12, pc + 32'd4);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain", exp_q.size(), 0);

        // Reset mid-cycle overrides the pending instruction; first edge after release samples new inputs.
        @(negedge clk);
        set_in(F_JP, 32'd500, 32'd0, 32'd0, 5'd3, 3'd0, 1'b0, 32'd16);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.result", result, 32'd0);
        chk("rst_mid.next_pc", next_pc, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold.result", result, 32'd0);
        chk("rst_hold.dest", {27'd0, dest_o}, 32'd0);
        reset = 1'b0;
        drive("post_rst", F_LD, 32'd40, 32'd2, 32'd0, 5'd14, 3'd0, 1'b0, 32'd96, 32'd42, 5'd14, 32'd100);

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain2", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
